// File: rtl/ac_sequencer.sv
// Accumulator/link controller: accepts one AC command at a time, fetches a memory
// operand when needed, fires the one-hot ALU opcode for one cycle and writes back AC/E.
module ac_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [15:0] inpr,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] alu_ac,
  output logic [15:0] alu_dr,
  output logic [15:0] alu_inpr,
  output logic [6:0]  alu_opcode,
  input  logic [16:0] alu_out,
  output logic [15:0] ac,
  output logic        e,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'd0, OP_ADD = 4'd1, OP_LDA = 4'd2, OP_INP = 4'd3,
                         OP_CMA = 4'd4, OP_CIR = 4'd5, OP_CIL = 4'd6, OP_CLA = 4'd7,
                         OP_CLE = 4'd8, OP_CME = 4'd9, OP_INC = 4'd10;

  state_t      state_q, state_d;
  logic [15:0] ac_q, ac_d, dr_q, dr_d;
  logic        e_q, e_d;
  logic [3:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic        mem_req_q, mem_req_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [16:0] inc_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ac_q      <= '0;
      dr_q      <= '0;
      e_q       <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ac_q      <= ac_d;
      dr_q      <= dr_d;
      e_q       <= e_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd_op <= OP_LDA)      state_d = READ;
        else if (cmd_op <= OP_INC) state_d = EXEC;
      end
      READ: if (mem_ack) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign inc_sum = {1'b0, ac_q} + 17'd1;

  always_comb begin
    ac_d      = ac_q;
    e_d       = e_q;
    dr_d      = dr_q;
    op_d      = op_q;
    addr_d    = addr_q;
    mem_req_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        op_d      = cmd_op;
        addr_d    = cmd_addr;
        mem_req_d = (cmd_op <= OP_LDA);
        err_d     = (cmd_op > OP_INC);
      end
      READ: begin
        mem_req_d = !mem_ack;
        if (mem_ack) dr_d = mem_rdata;
      end
      EXEC: begin
        done_d = 1'b1;
        // Shifts and E-only ops are done here so ALU shift feedback is never needed.
        case (op_q)
          OP_AND, OP_LDA, OP_INP, OP_CMA: ac_d = alu_out[15:0];
          OP_ADD: {e_d, ac_d} = alu_out;
          OP_CIR: begin ac_d = {e_q, ac_q[15:1]}; e_d = ac_q[0];  end
          OP_CIL: begin ac_d = {ac_q[14:0], e_q}; e_d = ac_q[15]; end
          OP_CLA: ac_d = '0;
          OP_CLE: e_d  = 1'b0;
          OP_CME: e_d  = ~e_q;
          OP_INC: {e_d, ac_d} = inc_sum;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    alu_opcode = '0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_AND:  alu_opcode = 7'b0000001;
        OP_ADD:  alu_opcode = 7'b0000010;
        OP_LDA:  alu_opcode = 7'b0000100;
        OP_INP:  alu_opcode = 7'b0001000;
        OP_CMA:  alu_opcode = 7'b0010000;
        default: alu_opcode = 7'b0000000;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = addr_q;
  assign alu_ac   = ac_q;
  assign alu_dr   = dr_q;
  assign alu_inpr = inpr;
  assign ac       = ac_q;
  assign e        = e_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
